// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register bank that sits behind the SPI slave decoder.
// It provides RW control registers, an ID word, sticky error status,
// edge-captured interrupt flags with a mask, and optional strobe counters.
// Read data is registered, so it appears one clock after the read strobe.
// Build option: define SPI_REG_BANK_CNT_EN to include the WR_CNT/RD_CNT
// counters at 0x82/0x83. Without it those addresses are unmapped.
module spi_reg_bank #(
  parameter int          NUM_RW_REGS = 8,
  parameter logic [15:0] ID_VALUE    = 16'h5A01
) (
  input  logic                       i_master_clock,
  input  logic                       i_rst,
  input  logic                       i_spi_write,
  input  logic                       i_spi_read,
  input  logic [7:0]                 i_spi_addr,
  input  logic [15:0]                i_spi_data,
  input  logic [7:0]                 i_irq_src,
  output logic [15:0]                o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_irq,
  output logic [16*NUM_RW_REGS-1:0]  o_ctrl
);

  localparam logic [8:0] LP_NUM_RW     = 9'(NUM_RW_REGS);
  localparam logic [7:0] ADDR_ID       = 8'h80;
  localparam logic [7:0] ADDR_STATUS   = 8'h81;
  localparam logic [7:0] ADDR_WR_CNT   = 8'h82;
  localparam logic [7:0] ADDR_RD_CNT   = 8'h83;
  localparam logic [7:0] ADDR_IRQ_FLAG = 8'h84;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h85;

  logic [15:0] r_regs [NUM_RW_REGS];
  logic        r_err;
  logic [7:0]  r_last_wr_addr;
  logic [7:0]  r_irq_flags;
  logic [7:0]  r_irq_mask;
  logic [7:0]  r_prev_src;

  logic        w_is_rw;
  logic        w_is_cnt;
  logic        w_mapped;
  logic        w_writable;
  logic        w_wr_accept;
  logic        w_err_set;
  logic        w_err_clr;
  logic [7:0]  w_irq_edge;
  logic [7:0]  w_irq_clr;
  logic [15:0] w_status;
  logic [15:0] w_wr_cnt;
  logic [15:0] w_rd_cnt;
  logic [15:0] w_rd_word;

  // Address classification shared by the write, read and error logic.
  assign w_is_rw     = ({1'b0, i_spi_addr} < LP_NUM_RW);
  assign w_writable  = w_is_rw | w_is_cnt
                     | (i_spi_addr == ADDR_STATUS)
                     | (i_spi_addr == ADDR_IRQ_FLAG)
                     | (i_spi_addr == ADDR_IRQ_MASK);
  assign w_mapped    = w_writable | (i_spi_addr == ADDR_ID);
  assign w_wr_accept = i_spi_write & w_writable;

  // Unmapped accesses and write/read collisions both flag an error.
  assign w_err_set = ((i_spi_write | i_spi_read) & ~w_mapped)
                   | (i_spi_write & i_spi_read);
  assign w_err_clr = i_spi_write & (i_spi_addr == ADDR_STATUS) & i_spi_data[0];

  // Sources already high out of reset see prev_src=FF and never fire.
  assign w_irq_edge = i_irq_src & ~r_prev_src;
  assign w_irq_clr  = (i_spi_write && (i_spi_addr == ADDR_IRQ_FLAG)) ? i_spi_data[7:0] : 8'h00;

  assign w_status = {r_last_wr_addr, 6'b000000, o_irq, r_err};

`ifdef SPI_REG_BANK_CNT_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;

  assign w_is_cnt = (i_spi_addr == ADDR_WR_CNT) | (i_spi_addr == ADDR_RD_CNT);
  assign w_wr_cnt = r_wr_cnt;
  assign w_rd_cnt = r_rd_cnt;

  // Strobe counters; a write to a counter's address zeroes it and beats the increment.
  always_ff @(posedge i_master_clock or posedge i_rst) begin
    if (i_rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (i_spi_write && (i_spi_addr == ADDR_WR_CNT)) r_wr_cnt <= '0;
      else if (i_spi_write)                           r_wr_cnt <= r_wr_cnt + 16'd1;
      if (i_spi_write && (i_spi_addr == ADDR_RD_CNT)) r_rd_cnt <= '0;
      else if (i_spi_read)                            r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end
`else
  assign w_is_cnt = 1'b0;
  assign w_wr_cnt = '0;
  assign w_rd_cnt = '0;
`endif

  // General RW registers, written one clock after the strobe.
  always_ff @(posedge i_master_clock or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_RW_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        if (i_spi_write && (i_spi_addr == 8'(i))) r_regs[i] <= i_spi_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_ctrl
    assign o_ctrl[16*g +: 16] = r_regs[g];
  end

  // Status, interrupt flags/mask, source history and the registered irq output.
  always_ff @(posedge i_master_clock or posedge i_rst) begin
    if (i_rst) begin
      r_err          <= 1'b0;
      r_last_wr_addr <= '0;
      r_irq_flags    <= '0;
      r_irq_mask     <= '0;
      r_prev_src     <= 8'hFF;
      o_irq          <= 1'b0;
    end else begin
      r_err       <= w_err_set | (r_err & ~w_err_clr);
      r_irq_flags <= w_irq_edge | (r_irq_flags & ~w_irq_clr);
      r_prev_src  <= i_irq_src;
      o_irq       <= |(r_irq_flags & r_irq_mask);
      if (w_wr_accept) r_last_wr_addr <= i_spi_addr;
      if (i_spi_write && (i_spi_addr == ADDR_IRQ_MASK)) r_irq_mask <= i_spi_data[7:0];
    end
  end

  // Read multiplexer over the pre-edge register values; unmapped reads give 0.
  always_comb begin
    w_rd_word = '0;
    case (i_spi_addr)
      ADDR_ID:       w_rd_word = ID_VALUE;
      ADDR_STATUS:   w_rd_word = w_status;
      ADDR_WR_CNT:   w_rd_word = w_wr_cnt;
      ADDR_RD_CNT:   w_rd_word = w_rd_cnt;
      ADDR_IRQ_FLAG: w_rd_word = {8'h00, r_irq_flags};
      ADDR_IRQ_MASK: w_rd_word = {8'h00, r_irq_mask};
      default: begin
        for (int i = 0; i < NUM_RW_REGS; i++) begin
          if (i_spi_addr == 8'(i)) w_rd_word = r_regs[i];
        end
      end
    endcase
  end

  // Read return path: capture data and pulse valid one clock after the strobe.
  always_ff @(posedge i_master_clock or posedge i_rst) begin
    if (i_rst) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_spi_read;
      if (i_spi_read) o_rd_data <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed stimulus with a read-data scoreboard.
// Each read pushes its hand-computed expected word into a queue; a monitor
// pops and compares every time o_rd_valid is seen.
module tb_spi_reg_bank;

  localparam int NUM_RW = 8;

  logic                  clk;
  logic                  rst;
  logic                  spiWrite;
  logic                  spiRead;
  logic [7:0]            spiAddr;
  logic [15:0]           spiData;
  logic [7:0]            irqSrc;
  logic [15:0]           rdData;
  logic                  rdValid;
  logic                  irq;
  logic [16*NUM_RW-1:0]  ctrl;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] expData;
  } rdExp_t;

  rdExp_t expQ[$];
  int vectors = 0;
  int miscompares = 0;

  spi_reg_bank #(.NUM_RW_REGS(NUM_RW), .ID_VALUE(16'h5A01)) dut (
    .i_master_clock (clk),
    .i_rst          (rst),
    .i_spi_write    (spiWrite),
    .i_spi_read     (spiRead),
    .i_spi_addr     (spiAddr),
    .i_spi_data     (spiData),
    .i_irq_src      (irqSrc),
    .o_rd_data      (rdData),
    .o_rd_valid     (rdValid),
    .o_irq          (irq),
    .o_ctrl         (ctrl)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream stalls.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One strobe cycle starting just after a falling edge; reads queue their expectation.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                               input logic [15:0] data, input logic [15:0] expRd);
    rdExp_t e;
    spiWrite = wr;
    spiRead  = rd;
    spiAddr  = addr;
    spiData  = data;
    if (rd) begin
      e.addr    = addr;
      e.expData = expRd;
      expQ.push_back(e);
    end
    @(negedge clk);
    spiWrite = 1'b0;
    spiRead  = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rdValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("rd_unexpected_valid", 32'(rdValid), 32'h0);
      end else begin
        rdExp_t e;
        e = expQ.pop_front();
        checkOutput($sformatf("rd_addr_%02h", e.addr), 32'(rdData), 32'(e.expData));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    spiWrite = 1'b0;
    spiRead  = 1'b0;
    spiAddr  = '0;
    spiData  = '0;
    irqSrc   = 8'h01;
    repeat (2) @(negedge clk);
    checkOutput("reset_rd_data", 32'(rdData), 32'h0);
    checkOutput("reset_rd_valid", 32'(rdValid), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_ctrl_zero", 32'(|ctrl), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ID read with a single-cycle valid pulse.
    applyStimulus(1'b0, 1'b1, 8'h80, 16'h0, 16'h5A01);
    checkOutput("id_valid_high", 32'(rdValid), 32'h1);
    @(negedge clk);
    checkOutput("id_valid_drops", 32'(rdValid), 32'h0);

    // RW register write then read back, plus last-write address.
    applyStimulus(1'b1, 1'b0, 8'h03, 16'hABCD, 16'h0);
    checkOutput("ctrl_reg3", 32'(ctrl[63:48]), 32'h0000ABCD);
    applyStimulus(1'b0, 1'b1, 8'h03, 16'h0, 16'hABCD);
    applyStimulus(1'b0, 1'b1, 8'h81, 16'h0, 16'h0300);

    // Unmapped read sets err_sticky (back-to-back reads), then W1C.
    applyStimulus(1'b0, 1'b1, 8'h10, 16'h0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 8'h81, 16'h0, 16'h0301);
    applyStimulus(1'b1, 1'b0, 8'h81, 16'h0001, 16'h0);
    applyStimulus(1'b0, 1'b1, 8'h81, 16'h0, 16'h8100);

    // Interrupt path: mask bit2, pulse source bit2, irq rises a cycle after the flag.
    applyStimulus(1'b1, 1'b0, 8'h85, 16'h0004, 16'h0);
    irqSrc = 8'h05;
    @(negedge clk);
    irqSrc = 8'h01;
    checkOutput("irq_lag", 32'(irq), 32'h0);
    @(negedge clk);
    checkOutput("irq_rise", 32'(irq), 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h84, 16'h0, 16'h0004);
    applyStimulus(1'b0, 1'b1, 8'h81, 16'h0, 16'h8502);
    applyStimulus(1'b0, 1'b1, 8'h85, 16'h0, 16'h0004);

    // Set beats clear on the same flag bit.
    irqSrc = 8'h05;
    applyStimulus(1'b1, 1'b0, 8'h84, 16'h0004, 16'h0);
    irqSrc = 8'h01;
    applyStimulus(1'b0, 1'b1, 8'h84, 16'h0, 16'h0004);
    checkOutput("irq_held", 32'(irq), 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h84, 16'h0004, 16'h0);
    applyStimulus(1'b0, 1'b1, 8'h84, 16'h0, 16'h0000);
    checkOutput("irq_fall", 32'(irq), 32'h0);

    // Masked source: flag captured but irq stays low.
    irqSrc = 8'h03;
    @(negedge clk);
    irqSrc = 8'h01;
    repeat (2) @(negedge clk);
    checkOutput("irq_masked", 32'(irq), 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h84, 16'h0, 16'h0002);
    applyStimulus(1'b1, 1'b0, 8'h84, 16'h00FF, 16'h0);
    applyStimulus(1'b0, 1'b1, 8'h84, 16'h0, 16'h0000);

    // Collision: write performed, read returns prior value, err set.
    applyStimulus(1'b1, 1'b1, 8'h05, 16'h1234, 16'h0000);
    checkOutput("ctrl_reg5", 32'(ctrl[95:80]), 32'h00001234);
    applyStimulus(1'b0, 1'b1, 8'h05, 16'h0, 16'h1234);
    applyStimulus(1'b0, 1'b1, 8'h81, 16'h0, 16'h0501);
    applyStimulus(1'b1, 1'b0, 8'h81, 16'h0001, 16'h0);

`ifdef SPI_REG_BANK_CNT_EN
    // RD_CNT counts reads after being zeroed and reports the pre-increment value.
    applyStimulus(1'b1, 1'b0, 8'h83, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h00, 16'h0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 8'h83, 16'h0, 16'h0003);
    // WR_CNT zeroing beats its own increment, then wraps after 65536 writes.
    applyStimulus(1'b1, 1'b0, 8'h82, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b1, 8'h82, 16'h0, 16'h0000);
    for (int i = 0; i < 65535; i++) applyStimulus(1'b1, 1'b0, 8'h01, 16'h1111, 16'h0);
    applyStimulus(1'b0, 1'b1, 8'h82, 16'h0, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 8'h01, 16'h1111, 16'h0);
    applyStimulus(1'b0, 1'b1, 8'h82, 16'h0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 8'h81, 16'h0, 16'h0100);
`else
    // Counter addresses are unmapped in this build.
    applyStimulus(1'b0, 1'b1, 8'h83, 16'h0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 8'h81, 16'h0, 16'h8101);
`endif

    // Asynchronous reset during a pending read: no data comes back.
    spiRead = 1'b1;
    spiAddr = 8'h80;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_ctrl", 32'(|ctrl), 32'h0);
    @(negedge clk);
    spiRead = 1'b0;
    checkOutput("reset_pending_valid", 32'(rdValid), 32'h0);
    checkOutput("reset_pending_data", 32'(rdData), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
